// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among execution units, one
// registered broadcast plus one-cycle acknowledge per granted request.
module cdb_arbiter #(
    parameter int N     = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [N-1:0]         requireCDB,
    input  logic [N*TAG_W-1:0]   reqTag,
    input  logic [N*32-1:0]      reqData,
    input  logic                 flush,
    output logic [N-1:0]         requireAC,
    output logic                 cdbValid,
    output logic [TAG_W-1:0]     cdbTag,
    output logic [31:0]          cdbData,
    output logic [15:0]          bcastCount
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [TAG_W-1:0] tagArr  [N];
    logic [31:0]      dataArr [N];
    logic [N-1:0]     eligible;
    logic [IDX_W-1:0] lastGrant;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grantIdx;
    logic             grantFound;
    logic [N-1:0]     grantOneHot;
    logic [TAG_W-1:0] grantTag;
    logic [31:0]      grantData;

    for (genvar g = 0; g < N; g++) begin : gUnpack
        assign tagArr[g]  = reqTag[g*TAG_W +: TAG_W];
        assign dataArr[g] = reqData[g*32 +: 32];
    end

    // A unit being acked right now is still raising its request; masking it
    // keeps the same result from being broadcast twice.
    assign eligible = requireCDB & ~requireAC;

    always_comb begin
        cand        = lastGrant;
        grantIdx    = '0;
        grantFound  = 1'b0;
        grantOneHot = '0;
        for (int k = 0; k < N; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
            if (!grantFound && eligible[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
        if (grantFound) begin
            grantOneHot[grantIdx] = 1'b1;
        end
    end

    assign grantTag  = tagArr[grantIdx];
    assign grantData = dataArr[grantIdx];

    // Tag zero still gets acked so the unit cannot stall, but is never
    // broadcast as valid or counted.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            requireAC  <= '0;
            cdbValid   <= 1'b0;
            cdbTag     <= '0;
            cdbData    <= '0;
            bcastCount <= '0;
            lastGrant  <= LAST_IDX;
        end else if (flush || !grantFound) begin
            requireAC <= '0;
            cdbValid  <= 1'b0;
            cdbTag    <= '0;
            cdbData   <= '0;
        end else begin
            requireAC <= grantOneHot;
            cdbValid  <= (grantTag != '0);
            cdbTag    <= grantTag;
            cdbData   <= grantData;
            lastGrant <= grantIdx;
            if ((grantTag != '0) && (bcastCount != 16'hFFFF)) begin
                bcastCount <= bcastCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

    logic         clk;
    logic         nRST;
    logic [3:0]   requireCDB;
    logic [15:0]  reqTag;
    logic [127:0] reqData;
    logic         flush;
    logic [3:0]   requireAC;
    logic         cdbValid;
    logic [3:0]   cdbTag;
    logic [31:0]  cdbData;
    logic [15:0]  bcastCount;

    int checks;
    int failures;

    cdb_arbiter #(.N(4), .TAG_W(4)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .requireCDB (requireCDB),
        .reqTag     (reqTag),
        .reqData    (reqData),
        .flush      (flush),
        .requireAC  (requireAC),
        .cdbValid   (cdbValid),
        .cdbTag     (cdbTag),
        .cdbData    (cdbData),
        .bcastCount (bcastCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setUnit(input int idx, input logic [3:0] tag, input logic [31:0] data);
        reqTag[idx*4 +: 4]    = tag;
        reqData[idx*32 +: 32] = data;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic fl);
        requireCDB = req;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expAc, input logic expValid,
                               input logic [3:0] expTag, input logic [31:0] expData,
                               input logic [15:0] expCount);
        checks++;
        assert (requireAC === expAc) else begin
            failures++;
            $error("[TB] FAIL %s.requireAC got=%b exp=%b", name, requireAC, expAc);
        end
        checks++;
        assert (cdbValid === expValid) else begin
            failures++;
            $error("[TB] FAIL %s.cdbValid got=%b exp=%b", name, cdbValid, expValid);
        end
        checks++;
        assert (cdbTag === expTag) else begin
            failures++;
            $error("[TB] FAIL %s.cdbTag got=%h exp=%h", name, cdbTag, expTag);
        end
        checks++;
        assert (cdbData === expData) else begin
            failures++;
            $error("[TB] FAIL %s.cdbData got=%h exp=%h", name, cdbData, expData);
        end
        checks++;
        assert (bcastCount === expCount) else begin
            failures++;
            $error("[TB] FAIL %s.bcastCount got=%0d exp=%0d", name, bcastCount, expCount);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        reqTag   = '0;
        reqData  = '0;
        applyStimulus(4'b0000, 1'b0);
        setUnit(0, 4'd1, 32'h1111_0000);
        setUnit(1, 4'd2, 32'h2222_0001);
        setUnit(2, 4'd5, 32'hDEAD_BEEF);
        setUnit(3, 4'd4, 32'h4444_0003);

        // Reset state, then single request from unit 2
        #3;
        checkOutput("reset", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd0);
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("resetHeld", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd0);
        #4 nRST = 1'b1;
        tick();
        checkOutput("firstGrant", 4'b0100, 1'b1, 4'd5, 32'hDEAD_BEEF, 16'd1);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("idle1", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd1);

        // Reset pulse between edges so unit 0 has first priority again
        #2 nRST = 1'b0;
        #1;
        checkOutput("resetPulse", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd0);
        #1 nRST = 1'b1;
        setUnit(2, 4'd3, 32'h3333_0002);
        applyStimulus(4'b1111, 1'b0);
        tick();
        checkOutput("rr0", 4'b0001, 1'b1, 4'd1, 32'h1111_0000, 16'd1);
        tick();
        checkOutput("rr1", 4'b0010, 1'b1, 4'd2, 32'h2222_0001, 16'd2);
        tick();
        checkOutput("rr2", 4'b0100, 1'b1, 4'd3, 32'h3333_0002, 16'd3);
        tick();
        checkOutput("rr3", 4'b1000, 1'b1, 4'd4, 32'h4444_0003, 16'd4);
        tick();
        checkOutput("rr0again", 4'b0001, 1'b1, 4'd1, 32'h1111_0000, 16'd5);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("idle2", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd5);

        // Tag zero: acked but not broadcast or counted
        setUnit(1, 4'd0, 32'h5555_AAAA);
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("tagZero", 4'b0010, 1'b0, 4'd0, 32'h5555_AAAA, 16'd5);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("idle3", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd5);

        // Memory unit holds request through its ack cycle
        setUnit(3, 4'd9, 32'h9999_0003);
        applyStimulus(4'b1000, 1'b0);
        tick();
        checkOutput("memGrant", 4'b1000, 1'b1, 4'd9, 32'h9999_0003, 16'd6);
        tick();
        checkOutput("memNoDouble", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd6);
        tick();
        checkOutput("memFresh", 4'b1000, 1'b1, 4'd9, 32'h9999_0003, 16'd7);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("idle4", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd7);

        // Flush with units 0 and 2 requesting; lastGrant stays 3
        applyStimulus(4'b0101, 1'b1);
        tick();
        checkOutput("flush", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd7);
        applyStimulus(4'b0101, 1'b0);
        tick();
        checkOutput("afterFlush", 4'b0001, 1'b1, 4'd1, 32'h1111_0000, 16'd8);
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("afterFlush2", 4'b0100, 1'b1, 4'd3, 32'h3333_0002, 16'd9);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("idle5", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd9);

        // Async reset during a broadcast from unit 1
        setUnit(1, 4'd6, 32'h6666_0001);
        applyStimulus(4'b0010, 1'b0);
        tick();
        checkOutput("preReset", 4'b0010, 1'b1, 4'd6, 32'h6666_0001, 16'd10);
        #2 nRST = 1'b0;
        #1;
        checkOutput("midReset", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd0);
        applyStimulus(4'b0011, 1'b0);
        #1 nRST = 1'b1;
        tick();
        checkOutput("postReset0", 4'b0001, 1'b1, 4'd1, 32'h1111_0000, 16'd1);
        tick();
        checkOutput("postReset1", 4'b0010, 1'b1, 4'd6, 32'h6666_0001, 16'd2);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("idle6", 4'b0000, 1'b0, 4'd0, 32'h0, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
